// File: rtl/imm_ctrl_pkg.sv
// imm_ctrl_pkg: shared opcode, state, ALU and extender encodings for the multi-cycle control unit
package imm_ctrl_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_ANDI = 4'h5,
    OP_ORI  = 4'h6,
    OP_LW   = 4'h7,
    OP_SW   = 4'h8,
    OP_B    = 4'h9,
    OP_BEQ  = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;
  typedef enum logic [2:0] {CLS_ALU, CLS_LW, CLS_SW, CLS_B, CLS_BEQ, CLS_HALT} cls_e;
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_TRAP   = 3'd7;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN16 = 2'b01;
  localparam logic [1:0] EXT_SIGN20 = 2'b10;
endpackage

// File: rtl/imm_ctrl_decode.sv
// imm_ctrl_decode: combinational opcode decode into instruction class and datapath selects
module imm_ctrl_decode
  import imm_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output cls_e       cls,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic [1:0] ext_sel,
  output logic       illegal
);
  always_comb begin
    cls = CLS_ALU;
    alu_op = ALU_ADD;
    alu_src = 1'b0;
    ext_sel = EXT_ZERO;
    illegal = 1'b0;
    case (opcode)
      OP_ADD: ;
      OP_SUB: alu_op = ALU_SUB;
      OP_AND: alu_op = ALU_AND;
      OP_OR: alu_op = ALU_OR;
      OP_ADDI: begin alu_src = 1'b1; ext_sel = EXT_SIGN16; end
      OP_ANDI: begin alu_src = 1'b1; alu_op = ALU_AND; end
      OP_ORI: begin alu_src = 1'b1; alu_op = ALU_OR; end
      OP_LW: begin cls = CLS_LW; alu_src = 1'b1; ext_sel = EXT_SIGN16; end
      OP_SW: begin cls = CLS_SW; alu_src = 1'b1; ext_sel = EXT_SIGN16; end
      OP_B: begin cls = CLS_B; alu_op = ALU_SUB; ext_sel = EXT_SIGN20; end
      OP_BEQ: begin cls = CLS_BEQ; alu_op = ALU_SUB; ext_sel = EXT_SIGN20; end
      OP_HALT: cls = CLS_HALT;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_ctrl_fsm.sv
// imm_ctrl_fsm: multi-cycle control FSM with req/ack memory handshake and ack watchdog
module imm_ctrl_fsm
  import imm_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_W = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        addr_sel_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        pc_src_o,
  output logic        reg_we_o,
  output logic        wb_sel_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  ext_sel_o,
  output logic        halted_o,
  output logic        trap_o
);
  logic [2:0] state, nxt;
  logic [31:0] ir;
  logic [TO_W-1:0] wd;
  cls_e cls;
  logic [1:0] dec_op, dec_ext;
  logic dec_src, illegal, run, waiting, timeout, take, is_mem, unused_ir;
  imm_ctrl_decode u_decode (
    .opcode(ir[31:28]),
    .cls(cls),
    .alu_op(dec_op),
    .alu_src(dec_src),
    .ext_sel(dec_ext),
    .illegal(illegal)
  );
  assign unused_ir = ^ir[27:0];
  // every output is masked while reset is held so a late ack cannot load IR
  assign run = !rst_i;
  assign waiting = mem_req_o && !mem_ack_i;
  assign timeout = (ACK_TIMEOUT != 0) && waiting && (32'(wd) == 32'(ACK_TIMEOUT - 1));
  assign take = (cls == CLS_B) || (cls == CLS_BEQ && zero_i);
  assign is_mem = (cls == CLS_LW) || (cls == CLS_SW);
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH: nxt = mem_ack_i ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE: nxt = illegal ? S_TRAP : cls == CLS_HALT ? S_HALT
                    : (cls == CLS_B || cls == CLS_BEQ) ? S_BRANCH : S_EXEC;
      S_EXEC: nxt = is_mem ? S_MEM : S_WB;
      S_MEM: nxt = mem_ack_i ? (cls == CLS_SW ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
      S_WB, S_BRANCH: nxt = S_FETCH;
      default: nxt = state;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_FETCH;
      ir <= '0;
      wd <= '0;
    end else begin
      state <= nxt;
      if (ir_we_o) ir <= instr_i;
      wd <= (waiting && !timeout) ? wd + 1'b1 : '0;
    end
  end
  assign mem_req_o = run && (state == S_FETCH || state == S_MEM);
  assign mem_we_o = mem_req_o && state == S_MEM && cls == CLS_SW;
  assign addr_sel_o = run && state == S_MEM;
  assign ir_we_o = run && state == S_FETCH && mem_ack_i;
  assign pc_src_o = run && state == S_BRANCH && take;
  assign pc_we_o = ir_we_o || pc_src_o;
  assign reg_we_o = run && state == S_WB;
  assign wb_sel_o = reg_we_o && cls == CLS_LW;
  assign alu_src_o = run && state == S_EXEC && dec_src;
  assign alu_op_o = !run ? ALU_ADD : state == S_EXEC ? dec_op : state == S_BRANCH ? ALU_SUB : ALU_ADD;
  assign ext_sel_o = (run && state inside {S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH}) ? dec_ext : EXT_ZERO;
  assign halted_o = run && state == S_HALT;
  assign trap_o = run && state == S_TRAP;
endmodule
